// File: rtl/stimulus_conditioner.sv
// Per-channel stimulus conditioning: two-flop synchroniser, debounce, rising-edge latch,
// tick-aligned one-period delivery and habituation suppression for repeated stimuli.
module stimulus_conditioner #(
    parameter int N             = 7,
    parameter int DEBOUNCE      = 4,
    parameter int HABIT_LIMIT   = 3,
    parameter int HABIT_RECOVER = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] stimuli_raw,
    input  logic         tick,
    output logic [N-1:0] stimuli_out,
    output logic [N-1:0] habituated
);

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int HW = $clog2(HABIT_LIMIT + 1);
    localparam int QW = $clog2(HABIT_RECOVER + 1);

    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HABIT_LIMIT - 1);
    localparam logic [QW-1:0] Q_LAST = QW'(HABIT_RECOVER - 1);
    localparam logic [QW-1:0] Q_MAX  = QW'(HABIT_RECOVER);

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic          sync1;
        logic          sync2;
        logic          deb;
        logic [DW-1:0] dcnt;
        logic          pending;
        logic          out_q;
        logic          hab_q;
        logic [HW-1:0] hcnt;
        logic [QW-1:0] qcnt;
        logic          rise;

        // Rise coincides with the edge on which deb takes the new high level.
        assign rise = (sync2 != deb) && (dcnt == D_LAST) && sync2;

        assign stimuli_out[i] = out_q;
        assign habituated[i]  = hab_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1   <= 1'b0;
                sync2   <= 1'b0;
                deb     <= 1'b0;
                dcnt    <= '0;
                pending <= 1'b0;
                out_q   <= 1'b0;
                hab_q   <= 1'b0;
                hcnt    <= '0;
                qcnt    <= '0;
            end else begin
                sync1 <= stimuli_raw[i];
                sync2 <= sync1;

                if (sync2 == deb) begin
                    dcnt <= '0;
                end else if (dcnt == D_LAST) begin
                    deb  <= sync2;
                    dcnt <= '0;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end

                // An edge arriving on a tick cycle is kept for the following tick.
                pending <= (pending & ~tick) | rise;

                if (tick) begin
                    out_q <= pending & ~hab_q;
                    if (pending && !hab_q) begin
                        hcnt <= hcnt + 1'b1;
                        qcnt <= '0;
                        if (hcnt == H_LAST) begin
                            hab_q <= 1'b1;
                        end
                    end else if (pending) begin
                        qcnt <= '0;
                    end else if (hab_q && qcnt == Q_LAST) begin
                        hab_q <= 1'b0;
                        hcnt  <= '0;
                        qcnt  <= '0;
                    end else begin
                        if (qcnt != Q_MAX) begin
                            qcnt <= qcnt + 1'b1;
                        end
                        // A long quiet spell forgets earlier deliveries.
                        if (qcnt >= Q_LAST) begin
                            hcnt <= '0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_stimulus_conditioner.sv
// Self-checking bench for stimulus_conditioner: directed stimulus, a behavioural model
// checked every cycle, plus literal expectations at hand-computed edges.
module tb_stimulus_conditioner;

    localparam int N       = 7;
    localparam int D       = 4;
    localparam int LIMIT   = 3;
    localparam int RECOVER = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] raw;
    logic         tick;
    logic [N-1:0] stimuli_out;
    logic [N-1:0] habituated;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    stimulus_conditioner #(
        .N(N), .DEBOUNCE(D), .HABIT_LIMIT(LIMIT), .HABIT_RECOVER(RECOVER)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stimuli_raw(raw),
        .tick       (tick),
        .stimuli_out(stimuli_out),
        .habituated (habituated)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: a level is accepted once the last D samples all disagree with it.
    logic [N-1:0] m_s1, m_s2, m_deb, m_pend, m_out, m_hab;
    logic [D-1:0] m_hist [N];
    int           m_deliv [N];
    int           m_quiet [N];
    logic         md_s, md_rise;

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_pend = '0; m_out = '0; m_hab = '0;
            for (int i = 0; i < N; i++) begin
                m_hist[i]  = '0;
                m_deliv[i] = 0;
                m_quiet[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                md_s      = m_s2[i];
                m_hist[i] = {m_hist[i][D-2:0], md_s};
                md_rise   = 1'b0;
                if (m_hist[i] == {D{~m_deb[i]}}) begin
                    m_deb[i] = ~m_deb[i];
                    md_rise  = m_deb[i];
                end
                if (tick) begin
                    if (m_pend[i] && !m_hab[i]) begin
                        m_out[i] = 1'b1;
                        m_deliv[i]++;
                        m_quiet[i] = 0;
                        if (m_deliv[i] == LIMIT) m_hab[i] = 1'b1;
                    end else begin
                        m_out[i] = 1'b0;
                        if (m_pend[i]) begin
                            m_quiet[i] = 0;
                        end else begin
                            m_quiet[i]++;
                            if (m_hab[i] && m_quiet[i] == RECOVER) begin
                                m_hab[i]   = 1'b0;
                                m_deliv[i] = 0;
                                m_quiet[i] = 0;
                            end else if (m_quiet[i] >= RECOVER) begin
                                m_quiet[i] = RECOVER;
                                m_deliv[i] = 0;
                            end
                        end
                    end
                end
                m_pend[i] = md_rise | (m_pend[i] & ~tick);
                m_s2[i]   = m_s1[i];
                m_s1[i]   = raw[i];
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("stimuli_out_vs_model", int'(stimuli_out), int'(m_out));
            check("habituated_vs_model", int'(habituated), int'(m_hab));
        end
    end

    task automatic do_reset();
        rst  = 1'b1;
        tick = 1'b0;
        raw  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        tick = 1'b0;
        raw  = '0;
        @(negedge clk);
        do_reset();
        check("reset_out", int'(stimuli_out), 0);
        check("reset_hab", int'(habituated), 0);
        chk_en = 1;

        // Glitch shorter than the debounce window on channel 0.
        for (int e = 1; e <= 40; e++) begin
            raw    = '0;
            raw[0] = (e <= 3);
            tick   = (e % 16 == 0);
            @(negedge clk);
            if (e == 10) check("glitch_model_pend", int'(m_pend[0]), 0);
            if (e == 16 || e == 32) check("glitch_out0", int'(stimuli_out[0]), 0);
        end

        // Clean held press on channel 2, ticks at 10 and 26.
        do_reset();
        for (int e = 1; e <= 30; e++) begin
            raw    = '0;
            raw[2] = 1'b1;
            tick   = (e == 10 || e == 26);
            @(negedge clk);
            if (e == 5)  check("clean_pend_e5", int'(m_pend[2]), 0);
            if (e == 6)  check("clean_pend_e6", int'(m_pend[2]), 1);
            if (e == 9)  check("clean_out_e9", int'(stimuli_out[2]), 0);
            if (e == 10) check("clean_out_e10", int'(stimuli_out[2]), 1);
            if (e == 25) check("clean_out_e25", int'(stimuli_out[2]), 1);
            if (e == 26) check("clean_out_e26", int'(stimuli_out[2]), 0);
        end

        // Two presses between ticks on channel 1 coalesce into one pulse.
        do_reset();
        for (int e = 1; e <= 60; e++) begin
            raw    = '0;
            raw[1] = (e >= 1 && e <= 10) || (e >= 21 && e <= 30);
            tick   = (e == 40 || e == 56);
            @(negedge clk);
            if (e == 39) check("coal_out_e39", int'(stimuli_out[1]), 0);
            if (e == 40) check("coal_out_e40", int'(stimuli_out[1]), 1);
            if (e == 56) check("coal_out_e56", int'(stimuli_out[1]), 0);
        end

        // Rise on the same edge as a tick on channel 5 waits for the next tick.
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            raw    = '0;
            raw[5] = (e <= 20);
            tick   = (e == 6 || e == 22 || e == 38);
            @(negedge clk);
            if (e == 6)  check("simul_out_e6", int'(stimuli_out[5]), 0);
            if (e == 6)  check("simul_pend_e6", int'(m_pend[5]), 1);
            if (e == 22) check("simul_out_e22", int'(stimuli_out[5]), 1);
            if (e == 38) check("simul_out_e38", int'(stimuli_out[5]), 0);
        end

        // Habituation and recovery on channel 3.
        do_reset();
        for (int e = 1; e <= 216; e++) begin
            raw    = '0;
            raw[3] = (e <= 56 && (e % 16) >= 1 && (e % 16) <= 8) || (e >= 193 && e <= 200);
            tick   = (e % 16 == 0);
            @(negedge clk);
            if (e == 47)  check("habit_hab_e47", int'(habituated[3]), 0);
            if (e == 48)  check("habit_out_e48", int'(stimuli_out[3]), 1);
            if (e == 48)  check("habit_hab_e48", int'(habituated[3]), 1);
            if (e == 64)  check("habit_drop_e64", int'(stimuli_out[3]), 0);
            if (e == 191) check("habit_hab_e191", int'(habituated[3]), 1);
            if (e == 192) check("habit_hab_e192", int'(habituated[3]), 0);
            if (e == 208) check("habit_out_e208", int'(stimuli_out[3]), 1);
        end

        // Reset while channel 4 is pending and habituated, raw still held.
        do_reset();
        for (int e = 1; e <= 100; e++) begin
            raw    = '0;
            raw[4] = (e >= 1 && e <= 8) || (e >= 17 && e <= 24) || (e >= 33 && e <= 40) || (e >= 49);
            tick   = (e % 16 == 0);
            rst    = (e == 63 || e == 64);
            @(negedge clk);
            if (e == 62) check("rstmid_pend_e62", int'(m_pend[4]), 1);
            if (e == 62) check("rstmid_hab_e62", int'(habituated[4]), 1);
            if (e == 63) check("rstmid_out_e63", int'(stimuli_out), 0);
            if (e == 63) check("rstmid_hab_e63", int'(habituated), 0);
            if (e == 79) check("rstmid_out_e79", int'(stimuli_out[4]), 0);
            if (e == 80) check("rstmid_out_e80", int'(stimuli_out[4]), 1);
            if (e == 96) check("rstmid_out_e96", int'(stimuli_out[4]), 0);
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
